dice_roll_display: RTL and testbench
====================================

Name: dice_roll_display

Overview:
Consumer end of the dice random generator. It watches the generator's free-running value and latches it when the player presses the roll button, after a short "rolling" phase. It then checks the captured value against the selected die's legal range and converts it to BCD with a sequential double-dabble. Finally it drives two 7-segment digits (tens, units) plus a binary result for downstream logic.

Parameters:
ROLL_CYCLES, 16, number of clk cycles spent in ROLL before capture (legal 1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
dice  input  3  die select: 0=D4 1=D6 2=D8 3=D10 4=D12 5=D20 6=D30 7=D100
random  input  7  live value from the generator, changes every cycle
roll  input  1  roll push-button, asynchronous to clk
result  output  7  captured roll value (binary)
valid  output  1  high while result/segments hold a checked, converted roll
err  output  1  high while the captured roll is out of range for the latched die
busy  output  1  high from roll acceptance until valid/err is presented
seg_tens  output  7  tens digit, active-high, bit6..bit0 = a..g
seg_units  output  7  units digit, same encoding

Behaviour:
- Reset is async, active-high. It forces IDLE, the sync flops to 0, and every output to 0 (segments blank = 7'h00).
- roll input: passes through a 2-FF synchronizer, then a rising-edge detector.
  - Edge pulse E is one cycle wide, asserted in the cycle the 2nd flop first reads 1 after reading 0.
- States: IDLE, ROLL, CONVERT, SHOW.
- IDLE/SHOW + E:
  - Next cycle: ROLL, busy=1, valid=0, err=0.
  - dice is latched into dice_q (one-time capture; later dice changes are ignored until the next roll).
  - Roll counter is loaded with ROLL_CYCLES-1.
- Edges arriving while busy=1 are dropped, not queued.
- ROLL:
  - result follows random every cycle (animation). Both segments show dash 7'h01.
  - Counter decrements each cycle. In the cycle the counter is 0, random is latched into result and the FSM moves to CONVERT.
  - ROLL therefore lasts exactly ROLL_CYCLES cycles.
- CONVERT:
  - Exactly 7 cycles of shift-add-3 double dabble on the latched 7-bit value: one bit per cycle, add-3 to any BCD nibble >=5 before each shift. The range check runs in parallel.
  - result is held. Segments stay dash.
- Legal ranges by dice_q:
  - D4 1..4, D6 1..6, D8 1..8, D10 0..9, D12 1..12, D20 1..20, D30 1..30, D100 0..99.
  - Values 100..127 are always illegal.
- SHOW (entered the cycle after the 7th CONVERT cycle), busy=0.
  - Legal value: valid=1, err=0. Units digit = units BCD. Tens digit = tens BCD, blanked (7'h00) when tens==0.
  - Illegal value: valid=0, err=1. Both segments show E (7'h4F). result still holds the raw captured value.
  - SHOW holds indefinitely until the next E or reset.
- Digit encoding (a=bit6): 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B.
- Latency: from E to valid/err = 1 + ROLL_CYCLES + 7 cycles. busy is high for ROLL_CYCLES+7 cycles.
- Reset mid-ROLL/CONVERT: immediate return to IDLE with all outputs 0. A roll held high through reset release must not produce an edge until it has been seen low.
- Simultaneous E and last SHOW-holding cycle: a new roll starts normally, and valid/err drop the next cycle.
- An E in the same cycle as the ROLL->CONVERT transition is ignored.

Test Plan:
- Reset with roll=1, release, keep roll=1 for 50 cycles -> outputs stay 0, FSM stays in IDLE, no roll starts.
- dice=5 (D20), random forced to 17 in the capture cycle, roll pulse; ROLL_CYCLES=16 -> busy high 23 cycles.
  - Required response: result=17, valid=1, err=0, seg_tens=30, seg_units=70, exactly 24 cycles after E.
- dice=7 (D100), random=0 captured -> seg_tens=00 (blanked), seg_units=7E, valid=1.
  - random=99 -> seg_tens=7B, seg_units=7B.
- dice=0 (D4), random=0 captured -> err=1, valid=0, both segments 4F, result=0.
  - Repeat with random=5 -> same error display.
- Start a roll with dice=1 (D6), switch dice to 7 during ROLL, capture 50 -> err=1 (checked against the latched D6).
  - Extra roll pulses during busy produce no second roll.
- Assert rst mid-CONVERT -> all outputs 0 on the same edge. A fresh roll after release completes normally with a correct result.

Source files
------------

// File: rtl/dice_roll_display.sv
// Dice roll capture, range check and two-digit 7-segment display.
// Latches the generator value after a rolling phase, then double-dabbles it.
module dice_roll_display #(
  parameter int ROLL_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] dice,
  input  logic [6:0] random,
  input  logic       roll,
  output logic [6:0] result,
  output logic       valid,
  output logic       err,
  output logic       busy,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_units
);

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    CONV,
    SHOW
  } state_t;

  localparam logic [7:0] RC_LOAD = 8'(ROLL_CYCLES - 1);
  localparam logic [6:0] SEG_DASH = 7'h01;
  localparam logic [6:0] SEG_E = 7'h4F;

  state_t      state, state_nx;
  logic        s1, s2, s3;
  logic [1:0]  live;
  logic        armed;
  logic        edge_p;
  logic [7:0]  cnt;
  logic [2:0]  bcnt;
  logic [2:0]  dice_q;
  logic [14:0] dd;
  logic        ok_q;
  logic [3:0]  tens, units;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h7E;
      4'd1:    s = 7'h30;
      4'd2:    s = 7'h6D;
      4'd3:    s = 7'h79;
      4'd4:    s = 7'h33;
      4'd5:    s = 7'h5B;
      4'd6:    s = 7'h5F;
      4'd7:    s = 7'h70;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h7B;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic in_range(
    input logic [6:0] v,
    input logic [2:0] d
  );
    logic [6:0] lo, hi;
    lo = 7'd1;
    case (d)
      3'd0:    hi = 7'd4;
      3'd1:    hi = 7'd6;
      3'd2:    hi = 7'd8;
      3'd3:    begin hi = 7'd9; lo = 7'd0; end
      3'd4:    hi = 7'd12;
      3'd5:    hi = 7'd20;
      3'd6:    hi = 7'd30;
      default: begin hi = 7'd99; lo = 7'd0; end
    endcase
    return (v >= lo) && (v <= hi);
  endfunction

  // Add 3 to any BCD nibble >= 5, then shift in the next binary bit.
  function automatic logic [14:0] dab(input logic [14:0] v);
    logic [14:0] t;
    t = v;
    if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  // Synchronize roll; arm only after a real low has been sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      live  <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1    <= roll;
      s2    <= s1;
      s3    <= s2;
      live  <= {live[0], 1'b1};
      armed <= armed | (live[1] & ~s2);
    end
  end

  assign edge_p = s2 & ~s3 & armed;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; edges outside IDLE/SHOW are dropped.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, SHOW: if (edge_p) state_nx = ROLL;
      ROLL:       if (cnt == 8'd0) state_nx = CONV;
      CONV:       if (bcnt == 3'd0) state_nx = SHOW;
      default:    state_nx = IDLE;
    endcase
  end

  // Datapath: animation, capture, range check and conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 8'd0;
      bcnt   <= 3'd0;
      dice_q <= 3'd0;
      dd     <= 15'd0;
      ok_q   <= 1'b0;
      result <= 7'd0;
    end else begin
      case (state)
        IDLE, SHOW: begin
          if (edge_p) begin
            dice_q <= dice;
            cnt    <= RC_LOAD;
            result <= random;
          end
        end
        ROLL: begin
          result <= random;
          if (cnt == 8'd0) begin
            dd   <= {8'd0, random};
            bcnt <= 3'd6;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CONV: begin
          dd   <= dab(dd);
          bcnt <= bcnt - 3'd1;
          ok_q <= in_range(result, dice_q);
        end
        default: ;
      endcase
    end
  end

  assign tens  = dd[14:11];
  assign units = dd[10:7];

  // Status flags and segment drive from the current state.
  always_comb begin
    busy      = 1'b0;
    valid     = 1'b0;
    err       = 1'b0;
    seg_tens  = 7'h00;
    seg_units = 7'h00;
    unique case (1'b1)
      (state == ROLL), (state == CONV): begin
        busy      = 1'b1;
        seg_tens  = SEG_DASH;
        seg_units = SEG_DASH;
      end
      (state == SHOW) && ok_q: begin
        valid     = 1'b1;
        seg_tens  = (tens == 4'd0) ? 7'h00 : seg7(tens);
        seg_units = seg7(units);
      end
      (state == SHOW) && !ok_q: begin
        err       = 1'b1;
        seg_tens  = SEG_E;
        seg_units = SEG_E;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dice_roll_display.sv
// Randomized bench for dice_roll_display.
// Reference: range table, integer /10 %10 and a digit lookup.
module tb_dice_roll_display;

  localparam int R = 16;

  logic       clk;
  logic       rst;
  logic [2:0] dice;
  logic [6:0] random;
  logic       roll;
  logic [6:0] result;
  logic       valid;
  logic       err;
  logic       busy;
  logic [6:0] seg_tens;
  logic [6:0] seg_units;

  int n_chk;
  int n_pass;

  int lo_t[8]  = '{1, 1, 1, 0, 1, 1, 1, 0};
  int hi_t[8]  = '{4, 6, 8, 9, 12, 20, 30, 99};
  int seg_t[10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33,
                    'h5B, 'h5F, 'h70, 'h7F, 'h7B};

  dice_roll_display #(.ROLL_CYCLES(R)) dut (
    .clk(clk),
    .rst(rst),
    .dice(dice),
    .random(random),
    .roll(roll),
    .result(result),
    .valid(valid),
    .err(err),
    .busy(busy),
    .seg_tens(seg_tens),
    .seg_units(seg_units)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  function automatic bit legal_m(input int v, input int d);
    return v >= lo_t[d] && v <= hi_t[d];
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_res"}, result, 0);
    chk({tag, "_segs"}, {seg_tens, seg_units}, 0);
  endtask

  // One roll: d latched, cap captured. sw switches dice mid-roll,
  // xp adds extra presses while busy, ab aborts by reset in cycle ab.
  task automatic do_roll(input int d, input int cap, input bit sw,
                         input bit xp, input int ab);
    int k;
    int last_drv;
    int ev, et, eu;
    bit ok;
    roll = 1'b0;
    repeat (4) @(negedge clk);
    dice = 3'(d);
    roll = 1'b1;
    random = 7'($urandom);
    last_drv = random;
    k = 0;
    while (!busy && k < 12) begin
      @(negedge clk);
      k++;
      if (k == 3) roll = 1'b0;
      if (!busy) begin
        random = 7'($urandom);
        last_drv = random;
      end
    end
    roll = 1'b0;
    chk("start_lat", k, 3);
    if (!busy) return;
    for (int c = 1; c <= R + 7; c++) begin
      if (c == ab) begin
        rst = 1'b1;
        #1;
        chk_idle("abort");
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      chk("busy", busy, 1);
      chk("segs_dash", {seg_tens, seg_units}, 14'h0081);
      if (c <= R + 1) chk("res_anim", result, last_drv);
      else chk("res_hold", result, cap);
      if (c == 1) chk("flags_roll", {valid, err}, 0);
      random = (c == R) ? 7'(cap) : 7'($urandom);
      last_drv = random;
      if (sw && c == 3) dice = 3'd7;
      if (xp) begin
        if (c == 4 || c == R - 2) roll = 1'b1;
        if (c == 8 || c == R + 2) roll = 1'b0;
      end
      @(negedge clk);
    end
    roll = 1'b0;
    ok = legal_m(cap, d);
    ev = cap;
    et = ok ? ((ev / 10 == 0) ? 0 : seg_t[ev / 10]) : 'h4F;
    eu = ok ? seg_t[ev % 10] : 'h4F;
    for (int h = 0; h < 2; h++) begin
      chk("busy_end", busy, 0);
      chk("valid", valid, ok);
      chk("err", err, !ok);
      chk("result", result, cap);
      chk("seg_tens", seg_tens, et);
      chk("seg_units", seg_units, eu);
      random = 7'($urandom);
      repeat (6) @(negedge clk);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    roll   = 1'b1;
    dice   = 3'd0;
    random = 7'd0;
    repeat (3) @(negedge clk);
    chk_idle("rst");
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      random = 7'($urandom);
      @(negedge clk);
      if (i % 10 == 9) chk_idle("held");
    end
    do_roll(5, 17, 0, 0, 0);
    do_roll(7, 0, 0, 0, 0);
    do_roll(7, 99, 0, 0, 0);
    do_roll(0, 0, 0, 0, 0);
    do_roll(0, 5, 0, 0, 0);
    do_roll(1, 50, 1, 1, 0);
    do_roll(3, 7, 0, 0, R + 3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) chk_idle("post_abort");
    end
    do_roll(2, 8, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      do_roll(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
              0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
